// File: rtl/truth_table_checker.sv
// truth_table_checker
// -------------------
// Clocked self-test sequencer for a 3-input / 1-output combinational block.
// On an accepted start it walks the vector index 0..7 onto {x,y,z}. Each
// vector is held for SETTLE cycles and then sampled in one extra cycle.
// The sampled bits form the captured truth table, which is compared bit by
// bit against EXPECTED.
//
// Parameters:
//   EXPECTED  expected truth table, bit k = required dut_out for {x,y,z}=k
//   SETTLE    settle cycles per vector before the sample cycle (1..15)
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   start        in   begin a sweep (only looked at in IDLE)
//   dut_out      in   output of the block under control
//   x, y, z      out  vector index bits (MSB..LSB) driving the block
//   busy         out  high in SETTLE and SAMPLE states
//   done         out  one-cycle pulse in the DONE state
//   pass         out  captured table equals EXPECTED (valid from done)
//   result       out  captured truth table
//   mismatch     out  result ^ EXPECTED, per-vector error flags
//   err_count    out  number of set bits in mismatch
//   o_dbg_state  out  current FSM state, for checkers and debug
//
// Handshake: start is a level sampled on each rising edge while in IDLE.
// There is no back-pressure; a start seen in any other state is dropped.
// done is a Moore pulse of exactly one cycle per completed sweep.
module truth_table_checker #(
  parameter logic [7:0] EXPECTED = 8'hE8,
  parameter int         SETTLE   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_out,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] result,
  output logic [7:0] mismatch,
  output logic [3:0] err_count,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] LP_CNT_LAST = 4'(SETTLE - 1);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_idx;
  logic [3:0] r_cnt;
  logic [7:0] r_result;
  logic [7:0] r_mismatch;
  logic [3:0] r_err_count;
  logic       r_pass;
  logic       w_miss;

  // Error flag for the vector currently on {x,y,z}; only used in SAMPLE.
  assign w_miss = dut_out ^ EXPECTED[r_idx];

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_SETTLE;
      S_SETTLE: if (r_cnt == LP_CNT_LAST) w_next = S_SAMPLE;
      S_SAMPLE: w_next = (r_idx == 3'd7) ? S_DONE : S_SETTLE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // State register and datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= 3'd0;
      r_cnt       <= 4'd0;
      r_result    <= 8'h00;
      r_mismatch  <= 8'h00;
      r_err_count <= 4'd0;
      r_pass      <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx       <= 3'd0;
            r_cnt       <= 4'd0;
            r_result    <= 8'h00;
            r_mismatch  <= 8'h00;
            r_err_count <= 4'd0;
            r_pass      <= 1'b0;
          end
        end
        S_SETTLE: begin
          r_cnt <= r_cnt + 4'd1;
        end
        S_SAMPLE: begin
          r_result[r_idx]   <= dut_out;
          r_mismatch[r_idx] <= w_miss;
          if (w_miss) r_err_count <= r_err_count + 4'd1;
          if (r_idx == 3'd7) begin
            // Bits 0..6 are final here and bit 7 is being decided now, so
            // pass is already correct in the DONE cycle.
            r_pass <= (r_mismatch[6:0] == 7'd0) && !w_miss;
          end else begin
            r_idx <= r_idx + 3'd1;
            r_cnt <= 4'd0;
          end
        end
        S_DONE: begin
          r_idx <= 3'd0;
        end
        default: begin
          r_idx <= 3'd0;
        end
      endcase
    end
  end

  // Outputs are registers or decoded from state only.
  assign {x, y, z}   = r_idx;
  assign busy        = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
  assign done        = (r_state == S_DONE);
  assign pass        = r_pass;
  assign result      = r_result;
  assign mismatch    = r_mismatch;
  assign err_count   = r_err_count;
  assign o_dbg_state = r_state;

endmodule
